// File: rtl/set_scan_ctrl_pkg.sv
// set_scan_ctrl_pkg: shared constants and state encoding for the SET scan sequencer
package set_scan_ctrl_pkg;
  localparam int ROW_SZ   = 4;
  localparam int CNT_SZ   = 7;
  localparam int GRID_PTS = 64;
  localparam int PASS_PTS = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/set_scan_ctrl_hit_pipe.sv
// set_hit_pipe: LAT-deep shift register marking cycles whose hit_i belongs to the scan
module set_hit_pipe #(
  parameter int LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);
  logic [LAT-1:0] sr;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) sr <= '0;
    else sr <= flush_i ? '0 : (sr << 1) | LAT'(d_i);
  assign q_o = sr[LAT-1];
endmodule

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: sequences an 8x8 grid scan in four two-row passes and counts membership hits
module set_scan_ctrl
  import set_scan_ctrl_pkg::*;
#(
  parameter int HIT_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              abort_i,
  input  logic              hit_i,
  output logic              coord_en_o,
  output logic [ROW_SZ-1:0] start_row_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [CNT_SZ-1:0] count_o
);
  state_t            st;
  logic              run;
  logic [5:0]        p;
  logic [1:0]        dc;
  logic [CNT_SZ-1:0] acc, acc_nxt;
  logic              tag;
  logic              start;
  assign start = !abort_i && en_i && (st == ST_IDLE || st == ST_DONE);
  set_hit_pipe #(.LAT(HIT_LAT)) u_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(abort_i),
    .d_i    (st == ST_SCAN && run),
    .q_o    (tag)
  );
  always_comb acc_nxt = acc + CNT_SZ'(tag & hit_i);
  // run=0 marks the generator load cycle that precedes point 0
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      st          <= ST_IDLE;
      run         <= 1'b0;
      p           <= '0;
      dc          <= '0;
      acc         <= '0;
      coord_en_o  <= 1'b0;
      start_row_o <= '0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      count_o     <= '0;
    end else if (abort_i) begin
      st         <= ST_IDLE;
      run        <= 1'b0;
      acc        <= '0;
      coord_en_o <= 1'b0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
    end else if (start) begin
      st          <= ST_SCAN;
      run         <= 1'b0;
      p           <= '0;
      acc         <= '0;
      coord_en_o  <= 1'b1;
      start_row_o <= ROW_SZ'(1);
      busy_o      <= 1'b1;
      valid_o     <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      coord_en_o <= 1'b0;
      valid_o    <= 1'b0;
      case (st)
        ST_SCAN:
          if (!run) run <= 1'b1;
          else begin
            p <= p + 6'd1;
            // reload lands alongside the 16th point of the current pass
            if (p[3:0] == 4'(PASS_PTS - 2) && p[5:4] != 2'd3) begin
              coord_en_o  <= 1'b1;
              start_row_o <= {1'b0, p[5:4] + 2'd1, 1'b1};
            end
            if (p == 6'(GRID_PTS - 1)) begin
              st <= ST_DRAIN;
              dc <= '0;
            end
          end
        ST_DRAIN: begin
          dc <= dc + 2'd1;
          if (dc == 2'(HIT_LAT - 1)) begin
            st      <= ST_DONE;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            count_o <= acc_nxt;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_set_scan_ctrl.sv
// tb_set_scan_ctrl: randomized cycle-accurate checks of set_scan_ctrl at HIT_LAT 2 and 4
module tb_set_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en[2], ab[2], hit[2], co[2], busy[2], val[2];
  logic [3:0] row[2];
  logic [6:0] cnt[2];
  logic [6:0] exp_cnt[2];
  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  set_scan_ctrl #(.HIT_LAT(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .en_i(en[0]), .abort_i(ab[0]), .hit_i(hit[0]),
    .coord_en_o(co[0]), .start_row_o(row[0]), .busy_o(busy[0]), .valid_o(val[0]), .count_o(cnt[0])
  );
  set_scan_ctrl #(.HIT_LAT(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .en_i(en[1]), .abort_i(ab[1]), .hit_i(hit[1]),
    .coord_en_o(co[1]), .start_row_o(row[1]), .busy_o(busy[1]), .valid_o(val[1]), .count_o(cnt[1])
  );

  // Cycle k counts from the cycle in which en_i is sampled; expectations come from the scan timeline.
  task automatic scan(input int s, input logic [63:0] hp, input int xen, input int abt,
                      input bit started, input bit chain);
    int L, last, q;
    bit live, ce, bz, vl;
    logic [3:0] er;
    L = s ? 4 : 2;
    last = abt >= 0 ? abt + 4 : (chain ? 66 + L : 68 + L);
    for (int k = started ? 1 : 0; k <= last; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        live = abt < 0 || k <= abt;
        ce = live && (k == 1 || k == 17 || k == 33 || k == 49);
        er = 4'(2 * ((k - 1) / 16) + 1);
        bz = live && k <= 65 + L;
        vl = live && k == 66 + L;
        if (vl) exp_cnt[s] = 7'($countones(hp));
        total++;
        if (co[s] !== ce) $display("FAIL coord_en dut%0d k=%0d got %b exp %b", s, k, co[s], ce);
        else passes++;
        total++;
        if (busy[s] !== bz) $display("FAIL busy dut%0d k=%0d got %b exp %b", s, k, busy[s], bz);
        else passes++;
        total++;
        if (val[s] !== vl) $display("FAIL valid dut%0d k=%0d got %b exp %b", s, k, val[s], vl);
        else passes++;
        total++;
        if (cnt[s] !== exp_cnt[s]) $display("FAIL count dut%0d k=%0d got %0d exp %0d", s, k, cnt[s], exp_cnt[s]);
        else passes++;
        if (ce) begin
          total++;
          if (row[s] !== er) $display("FAIL start_row dut%0d k=%0d got %0d exp %0d", s, k, row[s], er);
          else passes++;
        end
      end
      q = k - 2 - L;
      en[s]  = (k == 0 && !started) || k == xen || (chain && k == 66 + L);
      ab[s]  = k == abt;
      hit[s] = (q >= 0 && q < 64 && (abt < 0 || k <= abt)) ? hp[q] : 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      en[i] = 0; ab[i] = 0; hit[i] = 0; exp_cnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({co[i], busy[i], val[i], row[i], cnt[i]} !== 14'd0)
        $display("FAIL reset_state dut%0d got %b exp 0", i, {co[i], busy[i], val[i], row[i], cnt[i]});
      else passes++;
    end
    rst = 1'b1;
  endtask

  task automatic test_full();
    scan(0, '1, -1, -1, 0, 0);
  endtask

  task automatic test_endpoints();
    scan(0, 64'h8000_0000_0000_0001, -1, -1, 0, 0);
  endtask

  task automatic test_ignored_en();
    scan(0, rnd64(), 30, -1, 0, 0);
  endtask

  task automatic test_abort();
    scan(0, rnd64(), -1, 40, 0, 0);
    scan(0, rnd64(), -1, -1, 0, 0);
  endtask

  task automatic test_en_abort();
    @(negedge clk);
    en[0] = 1; ab[0] = 1; hit[0] = 1;
    @(negedge clk);
    en[0] = 0; ab[0] = 0; hit[0] = 0;
    total++;
    if (busy[0] !== 1'b0 || co[0] !== 1'b0) $display("FAIL en_abort busy/coord got %b%b exp 00", busy[0], co[0]);
    else passes++;
    total++;
    if (cnt[0] !== exp_cnt[0]) $display("FAIL en_abort count got %0d exp %0d", cnt[0], exp_cnt[0]);
    else passes++;
  endtask

  task automatic test_lat4_chain();
    logic [63:0] odd;
    odd = {32{2'b10}};
    scan(1, odd, -1, -1, 0, 1);
    scan(1, rnd64(), -1, -1, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      scan(0, rnd64(), -1, -1, 0, 0);
      scan(1, rnd64(), -1, -1, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en[0] = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      en[0] = 0; hit[0] = 1'($urandom_range(0, 1));
    end
    total++;
    if (busy[0] !== 1'b1) $display("FAIL pre_reset busy got %b exp 1", busy[0]);
    else passes++;
    #2 rst = 1'b0;
    #1;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    total++;
    if ({co[0], busy[0], val[0], row[0], cnt[0]} !== 14'd0)
      $display("FAIL async_reset outputs got %b exp 0", {co[0], busy[0], val[0], row[0], cnt[0]});
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      hit[0] = 1'($urandom_range(0, 1));
      total++;
      if ({co[0], busy[0], val[0], cnt[0]} !== 10'd0)
        $display("FAIL post_reset idle k=%0d got %b exp 0", k, {co[0], busy[0], val[0], cnt[0]});
      else passes++;
    end
    scan(0, rnd64(), -1, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full();
    test_endpoints();
    test_ignored_en();
    test_abort();
    test_en_abort();
    test_lat4_chain();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
